// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared types and defaults for the stream round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

  // Default beat width of the source and sink streams.
  localparam int DATA_W_DEF = 8;

  // Arbiter FSM: IDLE arbitrates (one bubble), LOCK forwards the grantee.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/stream_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority encoder. Returns the first
//               asserted request at or after ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import stream_pkg::*;
#(
  parameter int N     = 4,
  parameter int GID_W = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [GID_W-1:0] ptr,
  output logic [GID_W-1:0] gnt_idx,
  output logic             any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int w_idx;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      if (!any && req[w_idx]) begin
        any     = 1'b1;
        gnt_idx = GID_W'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stream_rr_arbiter
// Description : Packet-granular round-robin arbiter sharing one registered
//               valid/last/ready output stage between N source streams.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_rr_arbiter
  import stream_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int GID_W  = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      s_valid,
  input  logic [N-1:0]      s_last,
  input  logic [N*DATA_W-1:0] s_data,
  output logic [N-1:0]      s_ready,
  output logic              m_valid,
  output logic              m_last,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic [GID_W-1:0]  grant_id
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [GID_W-1:0]  r_rr_ptr;
  logic [GID_W-1:0]  w_rr_ptr_nxt;
  logic [GID_W-1:0]  r_grant_id;
  logic [GID_W-1:0]  w_grant_nxt;
  logic [GID_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_load_ok;
  logic              w_accept;
  logic              w_src_last;
  logic [DATA_W-1:0] w_src_data [N];
  logic              r_m_valid;
  logic              r_m_last;
  logic [DATA_W-1:0] r_m_data;

  // Split the flat data bus into one beat per source.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_src_data[gi] = s_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N     (N),
    .GID_W (GID_W)
  ) u_pick (
    .req     (s_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_pick_idx),
    .any     (w_pick_any)
  );

  // The output register may take a new beat when empty or being drained.
  assign w_load_ok  = !r_m_valid || m_ready;
  assign w_src_last = s_last[r_grant_id];
  assign w_accept   = (r_state == LOCK) && s_valid[r_grant_id] && w_load_ok;

  // Next-state, grant and pointer decisions; ready goes only to the grantee.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant_id;
    w_rr_ptr_nxt = r_rr_ptr;
    s_ready      = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_idx;
          w_state_nxt = LOCK;
        end
      end
      LOCK: begin
        s_ready[r_grant_id] = w_load_ok;
        if (w_accept && w_src_last) begin
          w_rr_ptr_nxt = (r_grant_id == GID_W'(N - 1)) ? '0 : r_grant_id + GID_W'(1);
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, grant index and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

  // Output stage: load accepted beats, clear valid once drained, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_last  <= w_src_last;
      r_m_data  <= w_src_data[r_grant_id];
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end

  assign m_valid  = r_m_valid;
  assign m_last   = r_m_last;
  assign m_data   = r_m_data;
  assign busy     = (r_state == LOCK);
  assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_rr_arbiter
// Description : Randomized bench for stream_rr_arbiter with a packet-level
//               reference model and directed boundary scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int GW = 2;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  s_valid;
  logic [N-1:0]  s_last;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]  s_ready;
  logic          m_valid;
  logic          m_last;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          busy;
  logic [GW-1:0] grant_id;

  stream_rr_arbiter #(.N(N), .DATA_W(DW), .GID_W(GW)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner of the output (-1 = arbitrating), pointer, output beat.
  int         md_owner;
  int         md_ptr;
  int         md_gid;
  bit         md_mv;
  bit         md_ml;
  logic [7:0] md_md;

  // Source packet generators.
  int         src_len    [N];
  int         src_beat   [N];
  int         force_low  [N];
  int         fixed_len  [N];
  bit         src_active [N];
  bit         renew      [N];
  logic [7:0] src_data   [N];
  int         valid_pct;
  int         ready_mode;
  bit         ready_tog;
  int         dut_grants[$];
  bit         prev_busy;

  function automatic void model_reset();
    md_owner = -1;
    md_ptr   = 0;
    md_gid   = 0;
    md_mv    = 1'b0;
    md_ml    = 1'b0;
    md_md    = 8'h00;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      s_valid[i] = src_active[i] && (force_low[i] == 0) && ($urandom_range(0, 99) < valid_pct);
      s_last[i]  = (src_beat[i] == src_len[i] - 1);
      s_data[i*DW +: DW] = src_data[i];
    end
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ready_tog;
      default: m_ready = ($urandom_range(0, 99) < 60);
    endcase
  endtask

  task automatic new_packet(input int i);
    src_len[i]    = (fixed_len[i] > 0) ? fixed_len[i] : int'($urandom_range(1, 5));
    src_beat[i]   = 0;
    src_data[i]   = 8'($urandom);
    src_active[i] = 1'b1;
  endtask

  // One clock: entered and left at posedge+1.
  task automatic cycle();
    logic [N-1:0] er;
    bit   load_ok, is_last;
    int   acc, n_owner, n_ptr, n_gid, idx;
    bit   n_mv, n_ml;
    logic [7:0] n_md;
    #4;
    er = '0;
    if (md_owner >= 0 && (!md_mv || m_ready)) er[md_owner] = 1'b1;
    check_eq("s_ready",  32'(s_ready), 32'(er));
    check_eq("busy",     32'(busy), 32'(md_owner >= 0));
    check_eq("grant_id", 32'(grant_id), md_gid);
    check_eq("m_valid",  32'(m_valid), 32'(md_mv));
    check_eq("m_last",   32'(m_last), 32'(md_ml));
    check_eq("m_data",   32'(m_data), 32'(md_md));
    if (busy && !prev_busy) dut_grants.push_back(int'(grant_id));
    prev_busy = busy;

    load_ok = !md_mv || m_ready;
    acc = -1;
    is_last = 1'b0;
    if (md_owner >= 0 && s_valid[md_owner] && load_ok) begin
      acc = md_owner;
      is_last = (src_beat[acc] == src_len[acc] - 1);
    end
    n_owner = md_owner; n_ptr = md_ptr; n_gid = md_gid;
    n_mv = md_mv; n_ml = md_ml; n_md = md_md;
    if (acc >= 0) begin
      n_mv = 1'b1; n_ml = is_last; n_md = src_data[acc];
    end else if (m_ready) begin
      n_mv = 1'b0; n_ml = 1'b0;
    end
    if (md_owner < 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (md_ptr + k) % N;
        if (s_valid[idx]) begin n_owner = idx; n_gid = idx; end
      end
    end else if (acc >= 0 && is_last) begin
      n_ptr   = (md_owner + 1) % N;
      n_owner = -1;
    end

    @(posedge clk);
    #1;
    md_owner = n_owner; md_ptr = n_ptr; md_gid = n_gid;
    md_mv = n_mv; md_ml = n_ml; md_md = n_md;
    if (acc >= 0) begin
      if (is_last) begin
        if (renew[acc]) new_packet(acc);
        else src_active[acc] = 1'b0;
      end else begin
        src_beat[acc]++;
        src_data[acc] = 8'($urandom);
      end
    end
    for (int i = 0; i < N; i++) if (force_low[i] > 0) force_low[i]--;
    ready_tog = ~ready_tog;
    drive_inputs();
  endtask

  // Asynchronous reset pulse placed between clock edges; sources restart packets.
  task automatic do_reset(input bit check_async);
    #2 rst_n = 1'b0;
    #1;
    if (check_async) begin
      check_eq("rst_m_valid", 32'(m_valid), 0);
      check_eq("rst_m_last",  32'(m_last), 0);
      check_eq("rst_busy",    32'(busy), 0);
      check_eq("rst_s_ready", 32'(s_ready), 0);
    end
    model_reset();
    for (int i = 0; i < N; i++) src_beat[i] = 0;
    prev_busy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_inputs();
  endtask

  function automatic bit all_drained();
    bit r;
    r = (md_owner < 0) && !md_mv;
    for (int i = 0; i < N; i++) if (src_active[i]) r = 1'b0;
    return r;
  endfunction

  initial begin
    int busy_cnt;
    bit seen;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 1; src_beat[i] = 0; force_low[i] = 0; fixed_len[i] = 0;
      src_active[i] = 1'b0; renew[i] = 1'b0; src_data[i] = 8'h00;
    end
    valid_pct = 100; ready_mode = 0; ready_tog = 1'b0; prev_busy = 1'b0;
    model_reset();
    drive_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("reset_m_valid", 32'(m_valid), 0);
    check_eq("reset_m_data",  32'(m_data), 0);
    check_eq("reset_grant",   32'(grant_id), 0);
    rst_n = 1'b1;

    // Single-beat packet from source 3.
    fixed_len[3] = 1; new_packet(3); src_data[3] = 8'hA5; drive_inputs();
    busy_cnt = 0; seen = 1'b0;
    repeat (8) begin
      cycle();
      if (busy) busy_cnt++;
      if (m_valid && !seen) begin
        seen = 1'b1;
        check_eq("t6_data", 32'(m_data), 32'h0000_00A5);
        check_eq("t6_last", 32'(m_last), 1);
      end
    end
    check_eq("t6_seen", 32'(seen), 1);
    check_eq("t6_busy_cycles", busy_cnt, 1);

    // All four request continuously with single-beat packets; pointer wraps.
    dut_grants.delete();
    for (int i = 0; i < N; i++) begin fixed_len[i] = 1; renew[i] = 1'b1; new_packet(i); end
    drive_inputs();
    for (int b = 0; b < 40 && dut_grants.size() < 5; b++) cycle();
    check_eq("t2_grants_done", 32'(dut_grants.size() >= 5), 1);
    for (int k = 0; k < 5; k++)
      if (dut_grants.size() > k) check_eq($sformatf("t2_grant%0d", k), dut_grants[k], exp_order[k]);
    for (int i = 0; i < N; i++) renew[i] = 1'b0;
    for (int b = 0; b < 60 && !all_drained(); b++) cycle();
    check_eq("t2_drain", 32'(all_drained()), 1);

    // Grantee stalls mid-packet while source 1 keeps requesting.
    fixed_len[0] = 4; fixed_len[1] = 1; renew[1] = 1'b1;
    new_packet(0); new_packet(1); drive_inputs();
    for (int b = 0; b < 40 && !(md_owner == 0 && src_beat[0] == 2); b++) cycle();
    check_eq("t4_reach_mid", 32'(md_owner == 0 && src_beat[0] == 2), 1);
    force_low[0] = 3; drive_inputs();
    repeat (3) begin
      cycle();
      check_eq("t4_lock_busy",  32'(busy), 1);
      check_eq("t4_lock_grant", 32'(grant_id), 0);
    end
    dut_grants.delete();
    for (int b = 0; b < 30 && dut_grants.size() < 1; b++) cycle();
    check_eq("t4_next_seen", 32'(dut_grants.size() >= 1), 1);
    if (dut_grants.size() >= 1) check_eq("t4_next_grant", dut_grants[0], 1);
    renew[1] = 1'b0;
    for (int b = 0; b < 60 && !all_drained(); b++) cycle();
    check_eq("t4_drain", 32'(all_drained()), 1);

    // Back-pressure toggling every cycle during a 4-beat packet.
    ready_mode = 1; fixed_len[2] = 4; new_packet(2); drive_inputs();
    repeat (30) cycle();
    ready_mode = 0;
    for (int b = 0; b < 30 && !all_drained(); b++) cycle();
    check_eq("t3_drain", 32'(all_drained()), 1);

    // Two 3-beat packets from sources 0 and 2 together.
    fixed_len[0] = 3; fixed_len[2] = 3; new_packet(0); new_packet(2); drive_inputs();
    for (int b = 0; b < 40 && !all_drained(); b++) cycle();
    check_eq("t1_drain", 32'(all_drained()), 1);

    // Random traffic with gaps and random back-pressure.
    for (int i = 0; i < N; i++) begin fixed_len[i] = 0; renew[i] = 1'b1; new_packet(i); end
    valid_pct = 70; ready_mode = 2; drive_inputs();
    repeat (1500) cycle();

    // Asynchronous reset in the middle of a packet.
    for (int b = 0; b < 100 && !(md_owner >= 0 && src_beat[md_owner] >= 1); b++) cycle();
    check_eq("t5_reach_mid", 32'(md_owner >= 0 && src_beat[md_owner] >= 1), 1);
    do_reset(1'b1);
    valid_pct = 100; ready_mode = 0; drive_inputs();
    dut_grants.delete();
    for (int b = 0; b < 20 && dut_grants.size() < 1; b++) cycle();
    check_eq("t5_grant_seen", 32'(dut_grants.size() >= 1), 1);
    if (dut_grants.size() >= 1) check_eq("t5_first_grant", dut_grants[0], 0);
    valid_pct = 70; ready_mode = 2;
    repeat (100) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
